// File: rtl/mbe_divider_pkg.sv
// Shared constants and types for the 48/24 restoring divider.
package div_pkg;
    localparam int DW = 24;
    localparam int NW = 2 * DW;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam logic [DW-1:0] Q_SAT = {DW{1'b1}};
endpackage

// File: rtl/mbe_divider_if.sv
// Operand/result handshake bundle for mbe_divider.
// valid/ready: a transfer happens on a rising clk edge where both valid and ready are high.
interface mbe_divider_if
    import div_pkg::*;
();
    logic          in_valid;
    logic          in_ready;
    logic [NW-1:0] dividend;
    logic [DW-1:0] divisor;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] quotient;
    logic [DW-1:0] remainder;
    logic          div_by_zero;
    logic          overflow;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/mbe_divider_div_step.sv
// One restoring-division iteration: shift in a dividend bit, subtract D if it fits.
module div_step
    import div_pkg::*;
(
    input  logic [DW:0]   p_i,
    input  logic          bit_i,
    input  logic [DW-1:0] d_i,
    output logic [DW:0]   p_o,
    output logic          q_o
);
    logic [DW+1:0] t;
    logic [DW+1:0] diff;

    // P < D keeps p_i[DW] clear, so T < 2^(DW+1); the top bit of diff is the borrow.
    assign t    = {p_i, bit_i};
    assign diff = t - {2'b00, d_i};
    assign q_o  = ~diff[DW+1];
    assign p_o  = q_o ? diff[DW:0] : t[DW:0];
endmodule

// File: rtl/mbe_divider.sv
// Sequential unsigned 48/24 restoring divider, one quotient bit per clock.
module mbe_divider
    import div_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    mbe_divider_if.slave bus,
    output div_state_t   state_o
);
    localparam logic [4:0] LAST_STEP = 5'(DW - 1);

    div_state_t    state_q, state_d;
    logic [4:0]    cnt_q, cnt_d;
    logic [DW:0]   p_q, p_d;
    logic [DW-1:0] n_q, n_d;
    logic [DW-1:0] d_q, d_d;
    logic [DW-1:0] quo_q, quo_d;
    logic [DW-1:0] rem_q, rem_d;
    logic          dbz_q, dbz_d;
    logic          ovf_q, ovf_d;
    logic [DW:0]   p_step;
    logic          q_bit;

    div_step u_step (
        .p_i   (p_q),
        .bit_i (n_q[DW-1]),
        .d_i   (d_q),
        .p_o   (p_step),
        .q_o   (q_bit)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        n_d     = n_q;
        d_d     = d_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    d_d     = bus.divisor;
                    p_d     = {1'b0, bus.dividend[NW-1:DW]};
                    n_d     = bus.dividend[DW-1:0];
                    // Error results are settled now; RUN then spends one cycle before DONE.
                    if (bus.divisor == '0) begin
                        dbz_d = 1'b1;
                        quo_d = Q_SAT;
                        rem_d = bus.dividend[DW-1:0];
                    end else if (bus.dividend[NW-1:DW] >= bus.divisor) begin
                        ovf_d = 1'b1;
                        quo_d = Q_SAT;
                        rem_d = '0;
                    end
                end
            end
            RUN: begin
                if (dbz_q || ovf_q) begin
                    state_d = DONE;
                end else begin
                    p_d   = p_step;
                    n_d   = {n_q[DW-2:0], 1'b0};
                    quo_d = {quo_q[DW-2:0], q_bit};
                    if (cnt_q == LAST_STEP) begin
                        state_d = DONE;
                        rem_d   = p_step[DW-1:0];
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                    dbz_d   = 1'b0;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            p_q     <= '0;
            n_q     <= '0;
            d_q     <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            n_q     <= n_d;
            d_q     <= d_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.in_ready    = (state_q == IDLE);
    assign bus.out_valid   = (state_q == DONE);
    assign bus.quotient    = quo_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.overflow    = ovf_q;
    assign state_o         = state_q;
endmodule
